// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_cfg
//  Brief    : Parametrised UART receiver. It handles 5-9 data bits, optional
//             odd/even parity and 1 or 2 stop bits. It has an input
//             synchroniser and reports parity and framing errors.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,  // clock cycles per bit, >= 4
  parameter int DATA_BITS    = 8,    // 5..9, LSB first
  parameter int PARITY_MODE  = 0,    // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1,    // 1 or 2
  parameter int SYNC_STAGES  = 2     // >= 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] c_half      = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] c_last      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_data_last = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] c_stop_last = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;

  // Shift the asynchronous line through the synchroniser. Reset loads 1
  // (idle line) so that reset cannot fake a start bit.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Receive state machine
  // --------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_q, perr_d;       // parity error of frame in flight
  logic                   ferr_q, ferr_d;       // stop-bit error of frame in flight
  logic                   dv_q, dv_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;

  logic                   par_xor;              // XOR of data bits and sampled parity bit
  logic                   ferr_now;             // frame error including current stop sample

  assign par_xor  = (^shreg_q) ^ rx_sync;
  assign ferr_now = ferr_q | ~rx_sync;

  // Next-state, sampling and output-update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_sync) begin
          state_d = S_START;
        end
      end

      // Re-check the line at the middle of the start bit. This rejects
      // glitches that are shorter than half a bit.
      S_START: begin
        if (cnt_q == c_half) begin
          cnt_d   = '0;
          state_d = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == c_last) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shreg_d[i] = rx_sync;
            end
          end
          if (idx_q == c_data_last) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Odd parity expects an odd total count of ones. Even parity expects
      // an even total count.
      S_PARITY: begin
        if (cnt_q == c_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = (PARITY_MODE == 1) ? ~par_xor : par_xor;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The clock edge that takes the last stop sample also registers the
      // strobe. The word and the flags become visible together in the next
      // cycle.
      S_STOP: begin
        if (cnt_q == c_last) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (idx_q == c_stop_last) begin
            idx_d      = '0;
            dv_d       = 1'b1;
            byte_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_now;
            state_d    = ferr_now ? S_WAIT_IDLE : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Hold off while a break or a stuck-low line is present. This stops
      // the receiver from starting a new frame on it.
      S_WAIT_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_sync) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any frame and clears the
  // held outputs.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_cfg
//  Brief    : Scoreboard testbench for uart_rx_cfg. Three instances cover
//             8N1, 8E1 and 7O2 at 16 clocks per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_a, rx_b, rx_c;
  logic dv_a, dv_b, dv_c;
  logic [7:0] byte_a, byte_b;
  logic [6:0] byte_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  // A: 8N1
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx_a), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
    .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Busy(busy_a));
  // B: 8E1
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx_b), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
    .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Busy(busy_b));
  // C: 7O2
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .SYNC_STAGES(2)) dut_c (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx_c), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
    .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Busy(busy_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         t0;    // cycle at which the start bit was driven
    int         lat;   // expected start-to-strobe latency, -1 = unchecked
    int         gap;   // expected cycles since previous strobe, -1 = unchecked
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;
  int last_a = 0, last_b = 0, last_c = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe,
                              input int lat, input int gap);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.t0 = cyc; e.lat = lat; e.gap = gap;
    return e;
  endfunction

  // A frame with a stop error leaves the receiver in WAIT_IDLE, so busy
  // stays high at the strobe. Otherwise busy falls together with it.
  task automatic check_entry(input string tag, input exp_t e, input logic [8:0] d,
                             input logic pe, input logic fe, input logic bsy, input int last);
    check({tag, "_byte"}, 32'(d), 32'(e.data));
    check({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
    check({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
    check({tag, "_busy_at_dv"}, 32'(bsy), 32'(e.ferr));
    if (e.lat >= 0) check({tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
    if (e.gap >= 0) check({tag, "_strobe_gap"}, 32'(cyc - last), 32'(e.gap));
  endtask

  // Monitors: the scoreboard checks every strobe against the oldest
  // expectation.
  always @(negedge clk) begin
    if (dv_a) begin
      if (q_a.size() == 0) check("a_unexpected_dv", 32'(dv_a), 32'd0);
      else begin
        e_a = q_a.pop_front();
        check_entry("a", e_a, {1'b0, byte_a}, perr_a, ferr_a, busy_a, last_a);
      end
      last_a = cyc;
    end
  end

  always @(negedge clk) begin
    if (dv_b) begin
      if (q_b.size() == 0) check("b_unexpected_dv", 32'(dv_b), 32'd0);
      else begin
        e_b = q_b.pop_front();
        check_entry("b", e_b, {1'b0, byte_b}, perr_b, ferr_b, busy_b, last_b);
      end
      last_b = cyc;
    end
  end

  always @(negedge clk) begin
    if (dv_c) begin
      if (q_c.size() == 0) check("c_unexpected_dv", 32'(dv_c), 32'd0);
      else begin
        e_c = q_c.pop_front();
        check_entry("c", e_c, {2'b0, byte_c}, perr_c, ferr_c, busy_c, last_c);
      end
      last_c = cyc;
    end
  end

  // Serial line drivers. All line changes happen 1 ns after a rising edge.
  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int which, input logic v);
    set_line(which, v);
    idle(CPB);
  endtask

  task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                            input bit par_en, input logic par_bit,
                            input int nstop, input logic stop_v);
    send_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(which, d[i]);
    if (par_en) send_bit(which, par_bit);
    for (int i = 0; i < nstop; i++) send_bit(which, stop_v);
  endtask

  function automatic logic calc_par(input logic [8:0] d, input int nbits, input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < nbits; i++) x ^= d[i];
    return (mode == 1) ? ~x : x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    idle(5);
    // Reset state
    check("reset_dv", 32'(dv_a), 32'd0);
    check("reset_byte", 32'(byte_a), 32'd0);
    check("reset_parity_err", 32'(perr_a), 32'd0);
    check("reset_frame_err", 32'(ferr_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 8N1, 0xA5: latency 2+1+7+16*9+1 = 155
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0, 155, -1));
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(20);

    // 8E1, 0x37 has five ones: parity bit 1 is correct, parity bit 0 is wrong
    q_b.push_back(mk(9'h037, 1'b0, 1'b0, -1, -1));
    send_frame(1, 9'h037, 8, 1'b1, 1'b1, 1, 1'b1);
    idle(2 * CPB);
    q_b.push_back(mk(9'h037, 1'b1, 1'b0, -1, -1));
    send_frame(1, 9'h037, 8, 1'b1, 1'b0, 1, 1'b1);
    idle(2 * CPB);

    // 8N1 framing error, then a stuck-low line, then a good frame
    q_a.push_back(mk(9'h000, 1'b0, 1'b1, -1, -1));
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0);
    idle(3 * CPB / 2);
    check("a_busy_while_line_low", 32'(busy_a), 32'd1);
    idle(3 * CPB / 2);
    set_line(0, 1'b1);
    idle(2 * CPB);
    check("a_busy_after_release", 32'(busy_a), 32'd0);
    q_a.push_back(mk(9'h05A, 1'b0, 1'b0, -1, -1));
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(2 * CPB);

    // 5-clock low glitch: rejected at the mid-start check
    set_line(0, 1'b0);
    idle(5);
    set_line(0, 1'b1);
    idle(10);
    check("glitch_busy", 32'(busy_a), 32'd0);
    check("glitch_byte_held", 32'(byte_a), 32'h5A);
    check("glitch_frame_err_held", 32'(ferr_a), 32'd0);
    check("glitch_parity_err_held", 32'(perr_a), 32'd0);
    idle(2 * CPB);

    // Reset in the middle of data bit 4 of 0xC3. The transmitter is reset
    // at the same time, so the line goes back to idle.
    send_bit(0, 1'b0);
    send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b0);
    set_line(0, 1'b0);
    idle(CPB / 2);
    rst_n = 1'b0;
    set_line(0, 1'b1);
    idle(1);
    rst_n = 1'b1;
    check("midreset_dv", 32'(dv_a), 32'd0);
    check("midreset_byte", 32'(byte_a), 32'd0);
    check("midreset_parity_err", 32'(perr_a), 32'd0);
    check("midreset_frame_err", 32'(ferr_a), 32'd0);
    check("midreset_busy", 32'(busy_a), 32'd0);
    idle(2 * CPB);
    q_a.push_back(mk(9'h03C, 1'b0, 1'b0, -1, -1));
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
    idle(2 * CPB);

    // 7O2 back-to-back: 0x41 then 0x7F, strobes 11*CPB apart
    q_c.push_back(mk(9'h041, 1'b0, 1'b0, -1, -1));
    send_frame(2, 9'h041, 7, 1'b1, calc_par(9'h041, 7, 1), 2, 1'b1);
    q_c.push_back(mk(9'h07F, 1'b0, 1'b0, -1, 11 * CPB));
    send_frame(2, 9'h07F, 7, 1'b1, calc_par(9'h07F, 7, 1), 2, 1'b1);
    idle(4 * CPB);

    check("a_missing_dv", 32'(q_a.size()), 32'd0);
    check("b_missing_dv", 32'(q_b.size()), 32'd0);
    check("c_missing_dv", 32'(q_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
